adam_periph_uart_ctrl: RTL and testbench

APB master that configures an adam_periph_uart instance after reset and then bridges two byte streams (TX in, RX out) to it by polling the UART status register over APB. Lets a non-processor client (debug bridge, boot loader) use the UART without firmware. Supports the ADAM pause handshake between APB transfers.

---
 rtl/adam_periph_uart_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_adam_periph_uart_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_periph_uart_ctrl.sv
// APB master that configures an adam_periph_uart after reset, then bridges byte streams to it
// by polling SR; supports the ADAM pause handshake between transfers.
module adam_periph_uart_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           BRR_VALUE  = 434,
  parameter logic [DATA_WIDTH-1:0] CR_VALUE   = 32'h0000_0807
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pause_req,
  output logic                    pause_ack,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    init_done,
  output logic                    err
);

  localparam logic [ADDR_WIDTH-1:0] DrAddr  = BASE_ADDR + ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] CrAddr  = BASE_ADDR + ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] SrAddr  = BASE_ADDR + ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] BrrAddr = BASE_ADDR + ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] IerAddr = BASE_ADDR + ADDR_WIDTH'(8'h10);

  typedef enum logic [2:0] {
    StInitBrr, StInitCr, StInitIer, StPoll, StTxWr, StRxRd, StPaused
  } state_e;

  state_e                  state_q, state_d, resume_q, resume_d;
  logic                    psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    pause_ack_q, pause_ack_d, rx_valid_q, rx_valid_d;
  logic [7:0]              rx_data_q, rx_data_d;
  logic                    init_done_q, init_done_d, err_q, err_d;
  logic                    xfer_done;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_write;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    unused_prdata;

  assign xfer_done     = psel_q & penable_q & pready;
  assign unused_prdata = ^prdata[DATA_WIDTH-1:8];

  // Transfer that the current state would issue when the bus is idle.
  always_comb begin
    req_addr  = SrAddr;
    req_write = 1'b0;
    req_wdata = '0;
    unique case (state_q)
      StInitBrr: begin
        req_addr  = BrrAddr;
        req_write = 1'b1;
        req_wdata = DATA_WIDTH'(BRR_VALUE);
      end
      StInitCr: begin
        req_addr  = CrAddr;
        req_write = 1'b1;
        req_wdata = CR_VALUE;
      end
      StInitIer: begin
        req_addr  = IerAddr;
        req_write = 1'b1;
      end
      StTxWr: begin
        req_addr  = DrAddr;
        req_write = 1'b1;
        req_wdata = {{(DATA_WIDTH-8){1'b0}}, tx_data};
      end
      StRxRd:  req_addr = DrAddr;
      default: req_addr = SrAddr;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pause_ack_d = pause_ack_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    err_d       = err_q;

    if (psel_q && !penable_q) penable_d = 1'b1;
    if (xfer_done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      if (pslverr) err_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      // A failed init write leaves the state unchanged so the same write is retried.
      StInitBrr: if (xfer_done && !pslverr) state_d = StInitCr;
      StInitCr:  if (xfer_done && !pslverr) state_d = StInitIer;
      StInitIer: begin
        if (xfer_done && !pslverr) begin
          state_d     = StPoll;
          init_done_d = 1'b1;
        end
      end
      StPoll: begin
        if (xfer_done && !pslverr) begin
          if (prdata[1] && !rx_valid_q)   state_d = StRxRd;
          else if (prdata[0] && tx_valid) state_d = StTxWr;
        end
      end
      StTxWr: if (xfer_done) state_d = StPoll;
      StRxRd: begin
        if (xfer_done) begin
          state_d = StPoll;
          if (!pslverr) begin
            rx_data_d  = prdata[7:0];
            rx_valid_d = 1'b1;
          end
        end
      end
      StPaused: begin
        if (!pause_req) begin
          pause_ack_d = 1'b0;
          state_d     = resume_q;
        end
      end
      default: state_d = StInitBrr;
    endcase

    // Pause is only honoured with the bus idle, so nothing is ever left outstanding.
    if (!psel_q && state_q != StPaused) begin
      if (pause_req) begin
        state_d     = StPaused;
        resume_d    = state_q;
        pause_ack_d = 1'b1;
      end else begin
        psel_d   = 1'b1;
        paddr_d  = req_addr;
        pwrite_d = req_write;
        pwdata_d = req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInitBrr;
      resume_q    <= StInitBrr;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pause_ack_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pause_ack_q <= pause_ack_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = '1;
  assign pause_ack = pause_ack_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign tx_ready  = (state_q == StTxWr) && xfer_done;

endmodule

// File: tb/tb_adam_periph_uart_ctrl.sv
// Bench for adam_periph_uart_ctrl: behavioural APB UART model with optional loopback,
// randomized byte traffic, bus-protocol monitor and per-feature test tasks.
module tb_adam_periph_uart_ctrl;

  localparam logic [31:0] Base = 32'h4000_1000;
  localparam logic [31:0] ADr  = Base + 32'h00;
  localparam logic [31:0] ACr  = Base + 32'h04;
  localparam logic [31:0] ASr  = Base + 32'h08;
  localparam logic [31:0] ABrr = Base + 32'h0C;
  localparam logic [31:0] AIer = Base + 32'h10;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pause_req = 1'b0, pause_ack;
  logic [31:0] paddr, pwdata, prdata = '0;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [7:0]  tx_data = '0, rx_data;
  logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, init_done, err;

  always #5 clk = ~clk;

  adam_periph_uart_ctrl #(.BASE_ADDR(Base)) dut (
    .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        er;
  } xfer_t;

  int compared = 0, mismatched = 0;
  xfer_t        log_q[$];
  byte unsigned rx_q[$];    // bytes the UART model holds for DR reads
  byte unsigned rx_got[$];  // bytes handed to the consumer
  int  ready_delay = 0, wait_cnt = 0, sr_force = -1;
  bit  loopback = 1'b0;
  logic [31:0] err_addr = '0;
  int  err_left = 0;
  int  tx_pulses = 0, proto_err = 0, paused_sel = 0;

  // UART slave model: answers on the falling edge so the DUT sees a settled response.
  always @(negedge clk) begin : slave
    xfer_t t;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (rst_n && psel && penable) begin
      if (wait_cnt < ready_delay) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        pready   = 1'b1;
        if (err_left > 0 && paddr == err_addr) begin
          pslverr = 1'b1;
          err_left--;
        end
        if (pwrite) begin
          if (paddr == ADr && !pslverr && loopback) rx_q.push_back(pwdata[7:0]);
        end else if (paddr == ASr) begin
          prdata = (sr_force >= 0) ? 32'(sr_force) : {30'b0, (rx_q.size() != 0), 1'b1};
        end else if (paddr == ADr && rx_q.size() != 0) begin
          prdata = {24'b0, rx_q[0]};
          if (!pslverr) void'(rx_q.pop_front());
        end
        t.addr = paddr;
        t.data = pwrite ? pwdata : prdata;
        t.wr   = pwrite;
        t.er   = pslverr;
        log_q.push_back(t);
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Protocol monitor.
  logic [64:0] snap = '0;
  bit prev_access = 0, tx_prev = 0, rx_hold = 0;
  logic [7:0] rx_prev = '0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_access = 0; tx_prev = 0; rx_hold = 0;
    end else begin
      if (tx_ready) begin
        tx_pulses++;
        if (tx_prev) proto_err++;
      end
      tx_prev = tx_ready;
      if (pause_ack && psel) paused_sel++;
      if (psel && !penable) begin
        if (prev_access) proto_err++;
        snap = {paddr, pwrite, pwdata};
      end
      if (psel && penable && {paddr, pwrite, pwdata} !== snap) proto_err++;
      if (penable && !psel) proto_err++;
      prev_access = psel && penable;
      if (rx_hold && rx_data !== rx_prev) proto_err++;
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      rx_hold = rx_valid && !rx_ready;
      rx_prev = rx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte unsigned b, output bit ok);
    int n;
    n = 0; ok = 0;
    tx_data = b; tx_valid = 1'b1;
    while (n < 300) begin
      @(negedge clk); #1;
      if (tx_ready) begin ok = 1; break; end
      n++;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_init(output bit ok);
    int n;
    n = 0;
    while (!init_done && n < 200) begin tick(1); n++; end
    ok = init_done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    compared++;
    if ({psel, penable, pwrite, pause_ack, tx_ready, rx_valid, init_done, err} !== 8'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {psel, penable, pwrite, pause_ack, tx_ready, rx_valid, init_done, err});
    end
    compared++;
    if ({paddr, pwdata, rx_data} !== 72'b0) begin
      mismatched++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rx_data=%h expected zeros",
               paddr, pwdata, rx_data);
    end
    compared++;
    if (pstrb !== 4'hF) begin
      mismatched++;
      $display("FAIL pstrb: got %h expected f", pstrb);
    end
  endtask

  task automatic test_init;
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    bit ok;
    ea = '{ABrr, ACr, AIer};
    ed = '{32'd434, 32'h807, 32'h0};
    log_q.delete();
    rst_n = 1'b1;
    wait_init(ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL init_done: got 0 expected 1"); end
    compared++;
    if (log_q.size() != 3) begin
      mismatched++;
      $display("FAIL init_count: got %0d transfers expected 3", log_q.size());
    end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      compared++;
      if (log_q[i].addr !== ea[i] || log_q[i].data !== ed[i] || log_q[i].wr !== 1'b1) begin
        mismatched++;
        $display("FAIL init_write%0d: got a=%h d=%h w=%b expected a=%h d=%h w=1", i,
                 log_q[i].addr, log_q[i].data, log_q[i].wr, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_tx;
    byte unsigned exp_q[$];
    logic [31:0] got_q[$];
    int idx, p0;
    bit ok;
    sr_force = 1;
    idx = log_q.size(); p0 = tx_pulses;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) begin
      send_byte(exp_q[i], ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL tx_accept%0d: got timeout expected tx_ready", i); end
    end
    tick(4);
    for (int i = idx; i < log_q.size(); i++)
      if (log_q[i].addr == ADr) got_q.push_back(log_q[i].wr ? log_q[i].data : 32'hDEAD);
    compared++;
    if (got_q.size() != exp_q.size() || tx_pulses - p0 != exp_q.size()) begin
      mismatched++;
      $display("FAIL tx_count: got %0d DR writes %0d pulses expected %0d", got_q.size(),
               tx_pulses - p0, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got_q[i] !== {24'b0, exp_q[i]}) begin
        mismatched++;
        $display("FAIL tx_data%0d: got %h expected %h", i, got_q[i], {24'b0, exp_q[i]});
      end
    end
    sr_force = -1;
  endtask

  task automatic test_rx_priority;
    xfer_t dr_q[$];
    int idx, p0, n, reads;
    sr_force = 3; rx_ready = 1'b0; rx_got.delete();
    idx = log_q.size(); p0 = tx_pulses;
    rx_q.push_back(8'h5C); rx_q.push_back(8'h77);
    tx_data = 8'h11; tx_valid = 1'b1;
    n = 0;
    while (tx_pulses == p0 && n < 200) begin tick(1); n++; end
    tx_valid = 1'b0;
    tick(20);
    for (int i = idx; i < log_q.size(); i++) if (log_q[i].addr == ADr) dr_q.push_back(log_q[i]);
    compared++;
    if (dr_q.size() != 2 || dr_q[0].wr !== 1'b0 || dr_q[1].wr !== 1'b1 ||
        dr_q[1].data !== 32'h11) begin
      mismatched++;
      $display("FAIL rx_first: got %0d DR accesses expected read then write of 00000011",
               dr_q.size());
    end
    compared++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5C) begin
      mismatched++;
      $display("FAIL rx_byte: got v=%b d=%h expected v=1 d=5c", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    compared++;
    if (rx_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rx_clear: got %b expected 0", rx_valid);
    end
    n = 0;
    while (!rx_valid && n < 100) begin tick(1); n++; end
    compared++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin
      mismatched++;
      $display("FAIL rx_next: got v=%b d=%h expected v=1 d=77", rx_valid, rx_data);
    end
    reads = 0;
    for (int i = idx; i < log_q.size(); i++) if (log_q[i].addr == ADr && !log_q[i].wr) reads++;
    compared++;
    if (reads != 2) begin
      mismatched++;
      $display("FAIL rx_reads: got %0d DR reads expected 2", reads);
    end
    sr_force = -1;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    compared++;
    if (rx_got.size() != 2 || rx_got[0] != 8'h5C || rx_got[1] != 8'h77) begin
      mismatched++;
      $display("FAIL rx_stream: got %0d bytes expected 5c 77", rx_got.size());
    end
  endtask

  task automatic test_pause;
    int n, p0, n0;
    logic [31:0] wdat;
    ready_delay = 3;
    wdat = {24'b0, 8'($urandom)};
    tx_data = wdat[7:0]; tx_valid = 1'b1; p0 = tx_pulses;
    n = 0;
    while (!(psel && pwrite && paddr == ADr) && n < 200) begin @(negedge clk); #1; n++; end
    pause_req = 1'b1;
    n = 0;
    while (tx_pulses == p0 && n < 50) begin @(negedge clk); #1; n++; end
    tick(1);
    tx_valid = 1'b0;
    compared++;
    if (log_q.size() == 0 || log_q[$].addr !== ADr || log_q[$].data !== wdat) begin
      mismatched++;
      $display("FAIL pause_wr_done: got last=%h expected DR write %h",
               log_q.size() ? log_q[$].addr : 32'h0, wdat);
    end
    n = 0;
    while (!pause_ack && n < 4) begin tick(1); n++; end
    compared++;
    if (pause_ack !== 1'b1) begin mismatched++; $display("FAIL pause_ack: got 0 expected 1"); end
    n0 = log_q.size();
    tick(12);
    compared++;
    if (log_q.size() != n0 || psel !== 1'b0) begin
      mismatched++;
      $display("FAIL pause_idle: got %0d transfers expected 0", log_q.size() - n0);
    end
    pause_req = 1'b0;
    tick(1);
    compared++;
    if (pause_ack !== 1'b0) begin mismatched++; $display("FAIL pause_drop: got 1 expected 0"); end
    tick(20);
    compared++;
    if (log_q.size() <= n0 || log_q[$].addr !== ASr) begin
      mismatched++;
      $display("FAIL pause_resume: got %0d new transfers expected SR polling", log_q.size() - n0);
    end
    ready_delay = 0;
  endtask

  task automatic test_stall_reset;
    int n;
    bit ok;
    ready_delay = 100000;
    n = 0;
    while (!(psel && penable) && n < 50) begin tick(1); n++; end
    tick(20);
    compared++;
    if (!(psel && penable)) begin
      mismatched++;
      $display("FAIL stall_hold: got psel=%b penable=%b expected 1 1", psel, penable);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({psel, penable, pwrite, pause_ack, rx_valid, init_done, err, paddr, pwdata} !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got psel=%b en=%b init=%b paddr=%h expected zeros",
               psel, penable, init_done, paddr);
    end
    ready_delay = 0;
    log_q.delete();
    err_addr = ACr; err_left = 1;
    tick(2);
    rst_n = 1'b1;
    wait_init(ok);
    compared++;
    if (!ok || err !== 1'b1) begin
      mismatched++;
      $display("FAIL slverr_init: got init=%b err=%b expected 1 1", ok, err);
    end
    compared++;
    if (log_q.size() != 4 || log_q[0].addr !== ABrr || log_q[1].addr !== ACr ||
        log_q[1].er !== 1'b1 || log_q[2].addr !== ACr || log_q[2].data !== 32'h807 ||
        log_q[3].addr !== AIer) begin
      mismatched++;
      $display("FAIL slverr_retry: got %0d init transfers expected BRR CR(err) CR IER",
               log_q.size());
    end
  endtask

  task automatic test_loopback;
    byte unsigned exp_q[$];
    int n;
    bit ok;
    loopback = 1'b1; rx_ready = 1'b1; rx_got.delete();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'($urandom_range(255, 0)));
      send_byte(exp_q[i], ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL loop_send%0d: got timeout expected tx_ready", i); end
    end
    n = 0;
    while (rx_got.size() < 10 && n < 500) begin tick(1); n++; end
    compared++;
    if (rx_got.size() != 10) begin
      mismatched++;
      $display("FAIL loop_count: got %0d bytes expected 10", rx_got.size());
    end
    for (int i = 0; i < rx_got.size() && i < 10; i++) begin
      compared++;
      if (rx_got[i] != exp_q[i]) begin
        mismatched++;
        $display("FAIL loop_byte%0d: got %h expected %h", i, rx_got[i], exp_q[i]);
      end
    end
    rx_ready = 1'b0; loopback = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_rx_priority();
    test_pause();
    test_stall_reset();
    test_loopback();
    compared++;
    if (proto_err != 0 || paused_sel != 0) begin
      mismatched++;
      $display("FAIL protocol: got %0d violations %0d paused selects expected 0 0",
               proto_err, paused_sel);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
